// File: rtl/note_panel_pkg.sv
// Shared types and constants for the tuner note panel pixel generator:
// controller state encoding, panel colours and the box placement helper.
package note_panel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TUNE = 2'd1,
    PLAY = 2'd2
  } state_t;

  // Colours in 3-bit RGB order {r, g, b}; the top resizes them to RGB_W.
  localparam logic [2:0] BOX_C      = 3'b001;
  localparam logic [2:0] HILITE_C   = 3'b010;
  localparam logic [2:0] PLAY_C     = 3'b100;
  localparam logic [2:0] PLAY_ACT_C = 3'b110;

  // Left-edge x coordinate of note box k; evaluated at elaboration only.
  function automatic int box_left(input int k, input int x0, input int box_w, input int gap);
    return x0 + k * (box_w + gap);
  endfunction

endpackage

// File: rtl/note_panel_graph_if.sv
// Pixel/tuner/play signal bundle between the video/tuner side (master)
// and the note panel generator (slave).
interface note_panel_graph_if #(
  parameter int N_NOTES = 8,
  parameter int COORD_W = 10,
  parameter int RGB_W   = 3
);
  import note_panel_pkg::*;

  localparam int IDX_W = $clog2(N_NOTES);

  logic               video_on;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               frame_tick;
  logic               note_valid;
  logic [IDX_W-1:0]   note_idx;
  logic               play_req;
  logic               play_busy;
  logic [IDX_W-1:0]   play_note;
  logic               play_strobe;
  logic               graph_on;
  logic [RGB_W-1:0]   graph_rgb;

  modport master (
    output video_on, pix_x, pix_y, frame_tick, note_valid, note_idx, play_req,
    input  play_busy, play_note, play_strobe, graph_on, graph_rgb
  );

  modport slave (
    input  video_on, pix_x, pix_y, frame_tick, note_valid, note_idx, play_req,
    output play_busy, play_note, play_strobe, graph_on, graph_rgb
  );

endinterface

// File: rtl/note_box_hit.sv
// Combinational inclusive rectangle test for one panel element.
module note_box_hit #(
  parameter int COORD_W = 10,
  parameter int X_L     = 0,
  parameter int X_R     = 0,
  parameter int Y_T     = 0,
  parameter int Y_B     = 0
) (
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic               hit
);

  localparam logic [COORD_W-1:0] XL = COORD_W'(X_L);
  localparam logic [COORD_W-1:0] XR = COORD_W'(X_R);
  localparam logic [COORD_W-1:0] YT = COORD_W'(Y_T);
  localparam logic [COORD_W-1:0] YB = COORD_W'(Y_B);

  // Pixel inside the rectangle, edges included.
  always_comb begin
    hit = (pix_x >= XL) && (pix_x <= XR) && (pix_y >= YT) && (pix_y <= YB);
  end

endmodule

// File: rtl/note_panel_graph.sv
// Note panel pixel generator: a row of N_NOTES boxes plus a play button.
// Highlights the tuner's detected note (held HOLD_FRAMES frames) or steps
// through all notes during a play sequence (STEP_FRAMES frames per note).
// Optional feature macro: BLINK_EN -- the tuner highlight blinks every 8 frames.
module note_panel_graph
  import note_panel_pkg::*;
#(
  parameter int N_NOTES     = 8,
  parameter int COORD_W     = 10,
  parameter int RGB_W       = 3,
  parameter int X0          = 32,
  parameter int Y0          = 160,
  parameter int BOX_W       = 64,
  parameter int BOX_H       = 96,
  parameter int GAP         = 8,
  parameter int PLAY_X_L    = 280,
  parameter int PLAY_X_R    = 360,
  parameter int PLAY_Y_T    = 320,
  parameter int PLAY_Y_B    = 360,
  parameter int HOLD_FRAMES = 60,
  parameter int STEP_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  note_panel_graph_if.slave bus
);

  localparam int IDX_W  = $clog2(N_NOTES);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int STEP_W = $clog2(STEP_FRAMES + 1);

  localparam logic [RGB_W-1:0] BOX_RGB      = RGB_W'(BOX_C);
  localparam logic [RGB_W-1:0] HILITE_RGB   = RGB_W'(HILITE_C);
  localparam logic [RGB_W-1:0] PLAY_RGB     = RGB_W'(PLAY_C);
  localparam logic [RGB_W-1:0] PLAY_ACT_RGB = RGB_W'(PLAY_ACT_C);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  hi_idx_reg, hi_idx_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [STEP_W-1:0] step_cnt_reg, step_cnt_next;
  logic [IDX_W-1:0]  play_note_reg, play_note_next;
  logic              play_strobe_reg, play_strobe_next;
  logic              graph_on_reg, graph_on_next;
  logic [RGB_W-1:0]  graph_rgb_reg, graph_rgb_next;

  logic [N_NOTES-1:0] box_hit;
  logic               play_hit;
  logic               box_any;
  logic [IDX_W-1:0]   hit_idx;
  logic               note_ok;
  logic               hl_en;
  logic [IDX_W-1:0]   hl_idx;
  logic               hl_lit;

  // Out-of-range indices are only possible when N_NOTES is not a power of two.
  assign note_ok = bus.note_valid && ({1'b0, bus.note_idx} < (IDX_W + 1)'(N_NOTES));

  // One rectangle test per note box, placed at elaboration time.
  for (genvar gi = 0; gi < N_NOTES; gi++) begin : g_box
    note_box_hit #(
      .COORD_W(COORD_W),
      .X_L    (box_left(gi, X0, BOX_W, GAP)),
      .X_R    (box_left(gi, X0, BOX_W, GAP) + BOX_W - 1),
      .Y_T    (Y0),
      .Y_B    (Y0 + BOX_H - 1)
    ) u_hit (
      .pix_x(bus.pix_x),
      .pix_y(bus.pix_y),
      .hit  (box_hit[gi])
    );
  end

  note_box_hit #(
    .COORD_W(COORD_W),
    .X_L    (PLAY_X_L),
    .X_R    (PLAY_X_R),
    .Y_T    (PLAY_Y_T),
    .Y_B    (PLAY_Y_B)
  ) u_play_hit (
    .pix_x(bus.pix_x),
    .pix_y(bus.pix_y),
    .hit  (play_hit)
  );

  // Priority-encode box hits; the lowest index wins (boxes never overlap anyway).
  always_comb begin
    hit_idx = '0;
    box_any = |box_hit;
    for (int i = N_NOTES - 1; i >= 0; i--) begin
      if (box_hit[i]) hit_idx = IDX_W'(i);
    end
  end

  // Controller next-state: play_req beats note_valid; ticks only count when no play_req.
  always_comb begin
    state_next       = state_reg;
    hi_idx_next      = hi_idx_reg;
    hold_cnt_next    = hold_cnt_reg;
    step_cnt_next    = step_cnt_reg;
    play_note_next   = play_note_reg;
    play_strobe_next = 1'b0;
    case (state_reg)
      IDLE, TUNE: begin
        if (bus.play_req) begin
          state_next       = PLAY;
          play_note_next   = '0;
          step_cnt_next    = '0;
          play_strobe_next = 1'b1;
        end else if (note_ok) begin
          state_next    = TUNE;
          hi_idx_next   = bus.note_idx;
          hold_cnt_next = '0;
        end else if (state_reg == TUNE && bus.frame_tick) begin
          if (hold_cnt_reg == HOLD_W'(HOLD_FRAMES - 1)) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end
      end
      PLAY: begin
        if (bus.frame_tick) begin
          if (step_cnt_reg == STEP_W'(STEP_FRAMES - 1)) begin
            step_cnt_next = '0;
            if (play_note_reg == IDX_W'(N_NOTES - 1)) begin
              state_next = IDLE;
            end else begin
              play_note_next   = play_note_reg + IDX_W'(1);
              play_strobe_next = 1'b1;
            end
          end else begin
            step_cnt_next = step_cnt_reg + STEP_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      hi_idx_reg      <= '0;
      hold_cnt_reg    <= '0;
      step_cnt_reg    <= '0;
      play_note_reg   <= '0;
      play_strobe_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hi_idx_reg      <= hi_idx_next;
      hold_cnt_reg    <= hold_cnt_next;
      step_cnt_reg    <= step_cnt_next;
      play_note_reg   <= play_note_next;
      play_strobe_reg <= play_strobe_next;
    end
  end

`ifdef BLINK_EN
  logic [2:0] blink_cnt_reg, blink_cnt_next;
  logic       blink_off_reg, blink_off_next;

  // Blink phase: restart lit on entry to TUNE, flip every 8 counted frames.
  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    blink_off_next = blink_off_reg;
    if (state_reg == IDLE && state_next == TUNE) begin
      blink_cnt_next = '0;
      blink_off_next = 1'b0;
    end else if (state_reg == TUNE && bus.frame_tick && !bus.play_req) begin
      blink_cnt_next = blink_cnt_reg + 3'd1;
      if (blink_cnt_reg == 3'd7) blink_off_next = ~blink_off_reg;
    end
  end

  // Blink counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt_reg <= '0;
      blink_off_reg <= 1'b0;
    end else begin
      blink_cnt_reg <= blink_cnt_next;
      blink_off_reg <= blink_off_next;
    end
  end

  assign hl_lit = (state_reg == PLAY) || !blink_off_reg;
`else
  assign hl_lit = 1'b1;
`endif

  assign hl_en  = (state_reg != IDLE);
  assign hl_idx = (state_reg == PLAY) ? play_note_reg : hi_idx_reg;

  // Pixel colour: boxes above play button; highlight only on the active note.
  always_comb begin
    graph_on_next  = 1'b0;
    graph_rgb_next = '0;
    if (bus.video_on) begin
      if (box_any) begin
        graph_on_next  = 1'b1;
        graph_rgb_next = (hl_en && hl_lit && hit_idx == hl_idx) ? HILITE_RGB : BOX_RGB;
      end else if (play_hit) begin
        graph_on_next  = 1'b1;
        graph_rgb_next = (state_reg == PLAY) ? PLAY_ACT_RGB : PLAY_RGB;
      end
    end
  end

  // Single pipeline stage on the pixel outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      graph_on_reg  <= 1'b0;
      graph_rgb_reg <= '0;
    end else begin
      graph_on_reg  <= graph_on_next;
      graph_rgb_reg <= graph_rgb_next;
    end
  end

  assign bus.play_busy   = (state_reg == PLAY);
  assign bus.play_note   = play_note_reg;
  assign bus.play_strobe = play_strobe_reg;
  assign bus.graph_on    = graph_on_reg;
  assign bus.graph_rgb   = graph_rgb_reg;

endmodule
